// File: rtl/ihm_pwm_ctrl.sv
`timescale 1ns/1ps
// Operator-interface motor controller: synchronised switches, RUN/BRAKE/STANDBY FSM, PWM drive and 7-seg readout.
// Optional feature: define IHM_SOFTSTART_EN to ramp the applied duty by one level per PWM period.
module ihm_pwm_ctrl #(
  parameter int PWM_WIDTH   = 8,
  parameter int LEVELS      = 9,
  parameter int START_LEVEL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       swt_start_stop,
  input  logic       swt_increase,
  input  logic       swt_decrease,
  output logic       motor_pwm,
  output logic       motor_running,
  output logic [3:0] level,
  output logic [6:0] display
);

  localparam int unsigned            STEP        = ((2 ** PWM_WIDTH) - 1) / LEVELS;
  localparam logic [3:0]             LEVEL_MAX   = 4'(LEVELS);
  localparam logic [3:0]             LEVEL_START = 4'(START_LEVEL);
  localparam logic [PWM_WIDTH-1:0]   CNT_MAX     = '1;
  localparam logic [PWM_WIDTH+3:0]   STEP_W      = (PWM_WIDTH + 4)'(STEP);

  typedef enum logic [1:0] {STANDBY, RUN, BRAKE} state_e;

  state_e               state_q;
  logic [3:0]           level_q;
  logic                 running_q;
  logic [1:0]           startSync_q;
  logic [2:0]           incSync_q;
  logic [2:0]           decSync_q;
  logic [PWM_WIDTH-1:0] cnt_q;
  logic [3:0]           duty_q;
  logic [3:0]           duty_d;
  logic                 pwm_q;
  logic                 pwm_d;
  logic [6:0]           display_q;
  logic [6:0]           display_d;
  logic [PWM_WIDTH+3:0] thresh;
  logic                 startS;
  logic                 incS;
  logic                 decS;
  logic                 incEdge;
  logic                 decEdge;

  assign startS  = startSync_q[1];
  assign incS    = incSync_q[1];
  assign decS    = decSync_q[1];
  assign incEdge = incSync_q[1] & ~incSync_q[2];
  assign decEdge = decSync_q[1] & ~decSync_q[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      startSync_q <= '0;
      incSync_q   <= '0;
      decSync_q   <= '0;
    end else begin
      startSync_q <= {startSync_q[0], swt_start_stop};
      incSync_q   <= {incSync_q[1:0], swt_increase};
      decSync_q   <= {decSync_q[1:0], swt_decrease};
    end
  end

  // Stop outranks everything, so edges coinciding with a stop or arriving in BRAKE are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= STANDBY;
      level_q   <= '0;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        STANDBY: begin
          if (startS) begin
            state_q   <= RUN;
            level_q   <= LEVEL_START;
            running_q <= 1'b1;
          end
        end
        RUN: begin
          if (!startS) begin
            state_q   <= STANDBY;
            level_q   <= '0;
            running_q <= 1'b0;
          end else if (incS && decS) begin
            state_q <= BRAKE;
          end else if (incEdge && !decS) begin
            if (level_q < LEVEL_MAX) level_q <= level_q + 4'd1;
          end else if (decEdge && !incS) begin
            if (level_q != 4'd0) level_q <= level_q - 4'd1;
          end
        end
        BRAKE: begin
          if (!startS) begin
            state_q   <= STANDBY;
            level_q   <= '0;
            running_q <= 1'b0;
          end else if (!(incS && decS)) begin
            state_q <= RUN;
          end
        end
        default: begin
          state_q   <= STANDBY;
          level_q   <= '0;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    duty_d = level_q;
`ifdef IHM_SOFTSTART_EN
    if (state_q == STANDBY) duty_d = '0;
    else if (duty_q < level_q) duty_d = duty_q + 4'd1;
`endif
  end

  // Full-scale level bypasses the compare so the drive stays high across the wrap.
  assign thresh = {{PWM_WIDTH{1'b0}}, duty_q} * STEP_W;
  assign pwm_d  = (state_q == RUN) &&
                  ((duty_q == LEVEL_MAX) || ({4'b0000, cnt_q} < thresh));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      pwm_q <= pwm_d;
      if (cnt_q == CNT_MAX) duty_q <= duty_d;
    end
  end

  always_comb begin
    display_d = 7'b0111111;
    case (level_q)
      4'd0: display_d = 7'b1000000;
      4'd1: display_d = 7'b1111001;
      4'd2: display_d = 7'b0100100;
      4'd3: display_d = 7'b0110000;
      4'd4: display_d = 7'b0011001;
      4'd5: display_d = 7'b0010010;
      4'd6: display_d = 7'b0000010;
      4'd7: display_d = 7'b1111000;
      4'd8: display_d = 7'b0000000;
      4'd9: display_d = 7'b0010000;
      default: display_d = 7'b0111111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) display_q <= 7'b1000000;
    else     display_q <= display_d;
  end

  assign motor_pwm     = pwm_q;
  assign motor_running = running_q;
  assign level         = level_q;
  assign display       = display_q;

endmodule

// File: tb/tb_ihm_pwm_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for ihm_pwm_ctrl: a behavioural model queues expected level/running/display/PWM
// per stimulus, and each entry is popped once the synchroniser latency has elapsed.
module tb_ihm_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       swtStartStop = 1'b0;
  logic       swtIncrease  = 1'b0;
  logic       swtDecrease  = 1'b0;
  logic       motorPwm;
  logic       motorRunning;
  logic [3:0] level;
  logic [6:0] display;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    int lvl;
    int run;
    int inRun;
    int disp;
    int high;
  } exp_t;

  exp_t expQ[$];

  int mState = 0;
  int mLevel = 0;
  bit prevInc = 1'b0;
  bit prevDec = 1'b0;

  logic [7:0] benchCnt;

  ihm_pwm_ctrl #(
    .PWM_WIDTH(8),
    .LEVELS(9),
    .START_LEVEL(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .swt_start_stop(swtStartStop),
    .swt_increase(swtIncrease),
    .swt_decrease(swtDecrease),
    .motor_pwm(motorPwm),
    .motor_running(motorRunning),
    .level(level),
    .display(display)
  );

  always #5 clk = ~clk;

  // Position within the PWM period, counted from reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) benchCnt <= 8'd0;
    else     benchCnt <= benchCnt + 8'd1;
  end

  function automatic int segDecode(input int l);
    case (l)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives the switches and advances the model to the state they should produce.
  task automatic applyStimulus(input bit ss, input bit inc, input bit dec);
    exp_t e;
    swtStartStop = ss;
    swtIncrease  = inc;
    swtDecrease  = dec;
    case (mState)
      0: if (ss) begin mState = 1; mLevel = 5; end
      1: begin
        if (!ss) begin mState = 0; mLevel = 0; end
        else if (inc && dec) mState = 2;
        else if (inc && !prevInc && !dec) begin if (mLevel < 9) mLevel++; end
        else if (dec && !prevDec && !inc) begin if (mLevel > 0) mLevel--; end
      end
      default: begin
        if (!ss) begin mState = 0; mLevel = 0; end
        else if (!(inc && dec)) mState = 1;
      end
    endcase
    prevInc = inc;
    prevDec = dec;
    e.lvl   = mLevel;
    e.run   = (mState != 0) ? 1 : 0;
    e.inRun = (mState == 1) ? 1 : 0;
    e.disp  = segDecode(mLevel);
    e.high  = (mState == 1) ? ((mLevel == 9) ? 256 : mLevel * 28) : 0;
    expQ.push_back(e);
  endtask

  task automatic observe(input bit doMeasure);
    exp_t e;
    int   highs;
    int   guard;
    repeat (3) @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 0, 1);
      return;
    end
    e = expQ.pop_front();
    checkOutput("level", int'(level), e.lvl);
    checkOutput("running", int'(motorRunning), e.run);
    @(posedge clk);
    #1;
    checkOutput("display", int'(display), e.disp);
    if (e.inRun == 0) checkOutput("pwmOff", int'(motorPwm), 0);
    if (doMeasure) begin
      guard = 0;
      do begin
        @(posedge clk);
        #1;
        guard++;
      end while (benchCnt != 8'd0 && guard < 300);
      if (benchCnt != 8'd0) checkOutput("pwmAlignTimeout", guard, 0);
      highs = 0;
      for (int i = 0; i < 256; i++) begin
        @(posedge clk);
        #1;
        if (motorPwm) highs++;
      end
      checkOutput("pwmHigh", highs, e.high);
    end
  endtask

  task automatic pulse(input bit inc, input bit dec, input bit doMeasure);
    applyStimulus(1'b1, inc, dec);
    observe(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    observe(doMeasure);
  endtask

  initial begin
    #12;
    checkOutput("rstLevel", int'(level), 0);
    checkOutput("rstRunning", int'(motorRunning), 0);
    checkOutput("rstPwm", int'(motorPwm), 0);
    checkOutput("rstDisplay", int'(display), 7'b1000000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b0, 1'b0);
    observe(1'b1);

    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0, (i == 5));
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, (i == 9));

    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, (i == 3));
    applyStimulus(1'b1, 1'b1, 1'b1);
    observe(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    observe(1'b1);

    applyStimulus(1'b0, 1'b1, 1'b0);
    observe(1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    observe(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    observe(1'b0);

    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);

    #3;
    rst = 1'b1;
    #1;
    checkOutput("midRstLevel", int'(level), 0);
    checkOutput("midRstRunning", int'(motorRunning), 0);
    checkOutput("midRstPwm", int'(motorPwm), 0);
    checkOutput("midRstDisplay", int'(display), 7'b1000000);
    swtStartStop = 1'b0;
    mState  = 0;
    mLevel  = 0;
    prevInc = 1'b0;
    prevDec = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("postRstRunning", int'(motorRunning), 0);
    checkOutput("postRstLevel", int'(level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ihm_pwm_ctrl.md
# ihm_pwm_ctrl

Parametrised operator-interface motor controller: takes the start/stop, increase and decrease switches and produces a PWM motor drive with a saturating speed level. It also produces a running flag and a 7-segment readout of the level. It sits between the board switches and the motor driver, and replaces the fixed on/off control with a true duty-cycle PWM.

## Interface
- PWM_WIDTH, 8: bit width of the PWM period counter; period = 2^PWM_WIDTH clk cycles.
- LEVELS, 9: maximum speed level (1..15); level range is 0..LEVELS.
- START_LEVEL, 5: level loaded on entering RUN; must be ≤ LEVELS.

- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- swt_start_stop  input  1  level switch, asynchronous to clk; 1 = run request.
- swt_increase  input  1  push switch, asynchronous; rising edge = level +1.
- swt_decrease  input  1  push switch, asynchronous; rising edge = level −1.
- motor_pwm  output  1  registered PWM drive.
- motor_running  output  1  registered; 1 in RUN and BRAKE.
- level  output  4  registered current target level.
- display  output  7  registered, active-low segments {g,f,e,d,c,b,a} showing level 0..9; 10..15 show "-" (7'b0111111).

## Operation
- All three switches pass through 2-FF synchronisers. Edge detect on the synchronised inc/dec uses a third flop; an edge is a 0→1 transition.
- FSM states:
  - STANDBY: level = 0, pwm = 0, running = 0. Goes to RUN when the synchronised start_stop is 1; level is loaded with START_LEVEL on that transition.
  - RUN:
    - Goes to STANDBY when start_stop = 0; level is cleared to 0.
    - Goes to BRAKE when the synchronised inc and dec are both 1.
    - Increase edge with dec = 0: level = min(level+1, LEVELS).
    - Decrease edge with inc = 0: level = max(level−1, 0).
  - BRAKE: pwm forced 0, running = 1, level held. Returns to RUN when inc and dec are not both 1. Goes to STANDBY when start_stop = 0, which has priority.
- Edges that occur during BRAKE, or in the same cycle as a stop, are discarded.
- PWM generation:
  - pwm_cnt is a free-running PWM_WIDTH-bit counter that wraps from 2^PWM_WIDTH−1 to 0.
  - STEP = floor((2^PWM_WIDTH−1)/LEVELS) is a localparam.
  - Applied duty register `duty` is loaded only when pwm_cnt = 2^PWM_WIDTH−1, so duty is glitch-free per period.
  - motor_pwm = RUN && (pwm_cnt < duty×STEP), except when the applied level = LEVELS, which forces 1 for the whole period.
  - Applied level 0 gives a constant 0 with running = 1.
- Defaults: STEP = 28. Level 5 gives 140 high cycles out of 256.

## Timing
- Reset: state = STANDBY; level = 0; duty = 0; pwm_cnt = 0; motor_pwm = 0; motor_running = 0; display = 7'b1000000; synchronisers = 0.
- Reset asserted mid-run returns everything to these values immediately, with no clock needed.
- Switch-to-state latency: an input change sampled at edge k is applied to state/level at edge k+2.
  - motor_running and level change at that same edge.
  - display follows one edge later.
- A level change reaches motor_pwm at the start of the next PWM period, and no earlier.
- Leaving RUN (to STANDBY or BRAKE) forces motor_pwm = 0 at the edge following the state change, regardless of period position.
- Simultaneous inc and dec edges in RUN: the level is unchanged and the FSM enters BRAKE.

## Configuration
- IHM_SOFTSTART_EN defined: the applied level ramps by +1 per PWM period toward the target level after entering RUN or after any increase, starting from 0 on entry to RUN. Decreases apply immediately at the next period boundary. The level output shows the target level.
- Not defined: applied level = target level at the next period boundary.

## Test plan
- Reset: assert rst mid-period while in RUN at level 7 -> all outputs go to their reset values asynchronously; display = 7'b1000000.
- Start: start_stop 0→1 -> running = 1 and level = 5 two edges after sampling. Without the macro, the next period has 140 high cycles of 256.
- Saturation: from level 5, six inc edges -> level 9 and motor_pwm constant 1. Then ten dec edges -> level 0 and motor_pwm 0 with running = 1.
- Brake: in RUN at level 4, hold inc = dec = 1 -> motor_pwm 0 within 1 edge of the state change, level stays 4. Release both -> PWM resumes at 112/256.
- Stop priority: drop start_stop in the same cycle as an inc edge -> STANDBY, level 0, no increment applied.
- Softstart (macro defined): start -> successive periods have 0, 28, 56, 84, 112, then 140 high cycles, which holds thereafter.
